// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM instruction-fetch stage.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_STEP          : byte increment between sequential word fetches
//   PC8_OFFSET       : R15 read offset seen by the decode stage (pc + 8)
//   fetch_entry_t    : one buffered fetch result {instr, pc}
package arm_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP    = 32'd4;
  localparam logic [ADDR_W-1:0] PC8_OFFSET = 32'd8;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch_entry_t between the imem response path and decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   flush      : clear the pointers; wins over push and pop
//   head       : entry at the head (meaningful only while count != 0)
//   count      : number of entries held, 0..DEPTH
// The storage array is never reset; only the pointers carry state that matters.
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  fetch_entry_t    mem [1 << IW];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wr_idx = IW'(wr_ptr % DEPTH);
  assign rd_idx = IW'(rd_ptr % DEPTH);
  assign count  = wr_ptr - rd_ptr;
  assign head   = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to instruction memory
// over a variable-latency req/resp interface, buffers returned words and hands
// {instr, pc, pc+8} to decode with a valid/ready handshake. A taken branch
// (redirect) flushes the buffer and discards responses still in flight.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   imem_req_valid/addr/ready          : fetch request channel (word addresses)
//   imem_resp_valid/data               : in-order response, one per accepted request
//   instr_valid/instr/instr_pc/pc8     : head of the fetch buffer toward decode
//   instr_ready                        : decode consumes the head this cycle
//   redirect, redirect_pc              : branch taken and its target
module instr_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc8,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     out_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic              drop_pend;
  logic              req_fire;
  logic              resp_keep;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign target = redirect_pc & ~32'h3;

  // Requests are gated by credit: every accepted request already owns a FIFO
  // slot, so responses can never be back-pressured.
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = reset && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle belongs to the old path and is discarded.
  assign drop_pend  = (drop != '0);
  assign resp_keep  = imem_resp_valid && !drop_pend && !redirect;
  assign push_entry = '{instr: imem_resp_data, pc: resp_pc};
  assign pop        = instr_valid && instr_ready;

  always_comb begin
    out_nxt = outstanding;
    if (req_fire)        out_nxt = out_nxt + CW'(1);
    if (imem_resp_valid) out_nxt = out_nxt - CW'(1);
  end

  // ---- request / response bookkeeping (registered) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // everything still in flight after this cycle belongs to the old path
        drop     <= out_nxt;
      end else begin
        if (req_fire)                    fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep)                   resp_pc  <= resp_pc + PC_STEP;
        if (imem_resp_valid && drop_pend) drop    <= drop - CW'(1);
      end
    end
  end

  // ---- fetch buffer toward decode ----
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (resp_keep),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .count (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign instr_pc8   = instr_valid ? (head.pc + PC8_OFFSET) : '0;

endmodule
